// File: rtl/muldiv_ctrl_pkg.sv
// Shared opcode encoding and helpers for the EX-stage multiply/divide sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // LO value written for a divide by zero (quotient saturates to all ones).
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the EX-stage multiply and divide units: latches one
// mult/multu/div/divu, drives mul/div, stalls EX while busy and issues a
// single HI/LO write when the result is ready.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        ex_hold,
  input  logic        flush,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam int unsigned CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          signed_q, signed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_op_e        op;

  assign op = md_op_e'(op_code);

  // State, operand, result and latency-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic and unit/pipeline control outputs.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    signed_d    = signed_q;
    cnt_d       = cnt_q;
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_annul   = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    stallreq    = 1'b0;
    hilo_we     = 1'b0;
    hi_wdata    = '0;
    lo_wdata    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          stallreq = 1'b1;
          a_d      = op_a;
          b_d      = op_b;
          signed_d = is_signed_op(op);
          if (!is_div(op)) begin
            cnt_d   = CW'(MUL_LAT);
            state_d = S_MUL_WAIT;
          end else if (op_b != '0) begin
            state_d = S_DIV_RUN;
          end else begin
            hi_d    = op_a;
            lo_d    = DIV0_LO;
            state_d = S_DONE;
          end
        end
      end
      S_MUL_WAIT: begin
        stallreq   = 1'b1;
        mul_signed = signed_q;
        mul_ina    = a_q;
        mul_inb    = b_q;
        if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_result;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV_RUN: begin
        stallreq    = 1'b1;
        div_signed  = signed_q;
        div_opdata1 = a_q;
        div_opdata2 = b_q;
        div_start   = !div_ready;
        div_annul   = flush;
        if (div_ready) begin
          {hi_d, lo_d} = div_result;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        hi_wdata = hi_q;
        lo_wdata = lo_q;
        if (!ex_hold) begin
          hilo_we = !flush;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over any completion in the same cycle, including a pending write.
    if (flush) begin
      state_d = S_IDLE;
      hilo_we = 1'b0;
    end
  end

endmodule
